// File: rtl/instruction_fetch.sv
// Instruction fetch FSM: one memory read per accepted fetch_start; misaligned addresses fault without touching memory.
// Latency 3 cycles with zero-wait memory; request and instruction outputs hold stable under backpressure on either handshake.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] program_count,
    input  logic                  fetch_start,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    input  logic                  mem_rsp_valid,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instruction_address,
    output logic                  instruction_valid,
    input  logic                  instruction_ready,
    output logic                  fetch_fault,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT,
        HOLD,
        DRAIN
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic                    fault_q;
    logic                    misaligned;
    logic                    accept;
    logic                    rsp_load;

    assign misaligned = (program_count[1:0] != 2'b00);

    // accept is the single point where a new fetch is taken, from IDLE or a consumed HOLD
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rsp_load  = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && fetch_start) begin
                    accept    = 1'b1;
                    state_nxt = misaligned ? HOLD : REQUEST;
                end
            end
            REQUEST: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nxt = mem_rsp_valid ? IDLE : DRAIN;
                end else if (mem_rsp_valid) begin
                    rsp_load  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (instruction_ready) begin
                    if (fetch_start) begin
                        accept    = 1'b1;
                        state_nxt = misaligned ? HOLD : REQUEST;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (mem_rsp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= program_count;
            instr_q <= '0;
            fault_q <= misaligned;
        end else if (rsp_load) begin
            instr_q <= mem_rsp_data;
            fault_q <= 1'b0;
        end
    end

    assign mem_addr            = addr_q;
    assign mem_req_valid       = (state == REQUEST);
    assign instruction         = instr_q;
    assign instruction_address = addr_q;
    assign instruction_valid   = (state == HOLD);
    assign fetch_fault         = fault_q;
    assign busy                = (state != IDLE);

endmodule
